// File: rtl/axi_dma_pkg.sv
// Shared definitions for the 2-D AXI read DMA: AXI burst/response encodings,
// the 4 KB page size, a constant-safe clog2 helper and the engine FSM states.
// No ports; imported by axi_dma_rd_2d and rd_data_fifo.
package axi_dma_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int AXI_4KB = 4096;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } dma_state_e;

endpackage

// File: rtl/rd_data_fifo.sv
// Synchronous first-word-fall-through FIFO holding returned read beats.
// Latency: a pushed word is visible at o_head_dat one cycle after the push edge.
// Backpressure: none internally; pushes when full / pops when empty are dropped.
// Ports: clk/rstn, i_push + i_push_dat (write), i_pop (consume head),
//        o_head_dat (head word), o_empty, o_full, o_count (occupancy).
module rd_data_fifo
  import axi_dma_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 32,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_empty,
  output logic             o_full,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign o_empty    = (count_q == '0);
  assign o_full     = (count_q == CW'(DEPTH));
  assign o_count    = count_q;
  assign o_head_dat = mem_q[rd_ptr_q];

  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is governed by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= i_push_dat;
    end
  end

endmodule

// File: rtl/axi_dma_rd_2d.sv
// AXI3 read DMA fetching a 2-D strided region (rows x row bytes) into a stream.
// Latency: first AR one cycle after i_start; R beat reaches o_valid one cycle after its handshake.
// Backpressure: ARs are issued only when FIFO space is reserved, so RREADY never drops mid-transfer.
// Ports: clk/rstn; i_start + config (base, row bytes, stride, rows); o_busy/o_done/o_err status;
//        M_AR* read-address master; M_R* read-data master; o_valid/o_data/o_last/i_ready stream.
module axi_dma_rd_2d
  import axi_dma_pkg::*;
#(
  parameter int A          = 32,
  parameter int I          = 4,
  parameter int L          = 8,
  parameter int D          = 32,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int AR_ID      = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_start,
  input  logic [A-1:0] i_base_addr,
  input  logic [15:0]  i_row_bytes,
  input  logic [A-1:0] i_row_stride,
  input  logic [15:0]  i_num_rows,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic         M_ARVALID,
  input  logic         M_ARREADY,
  output logic [A-1:0] M_ARADDR,
  output logic [I-1:0] M_ARID,
  output logic [L-1:0] M_ARLEN,
  output logic [2:0]   M_ARSIZE,
  output logic [1:0]   M_ARBURST,
  input  logic         M_RVALID,
  output logic         M_RREADY,
  input  logic [D-1:0] M_RDATA,
  input  logic         M_RLAST,
  input  logic [1:0]   M_RRESP,
  output logic         o_valid,
  output logic [D-1:0] o_data,
  output logic         o_last,
  input  logic         i_ready
);

  localparam int BPB = D / 8;
  localparam int SZ  = clog2(BPB);
  localparam int CW  = clog2(FIFO_DEPTH) + 1;

  dma_state_e  state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [A-1:0] row_start_q, row_start_d;
  logic [A-1:0] cur_addr_q, cur_addr_d;
  logic [A-1:0] stride_q, stride_d;
  logic [15:0] row_beats_q, row_beats_d;
  logic [15:0] beats_left_q, beats_left_d;
  logic [15:0] rows_left_q, rows_left_d;
  logic [31:0] total_q, total_d;
  logic [31:0] reserved_q, reserved_d;
  logic [31:0] rcvd_q, rcvd_d;
  logic [31:0] popped_q, popped_d;

  logic [31:0] beats_4k;
  logic [31:0] burst_beats;
  logic [15:0] start_row_beats;
  logic [15:0] beats_left_after;
  logic        credit_ok;
  logic        ar_vld;
  logic        ar_hs;
  logic        r_hs;
  logic        pop;
  logic        head_is_last;
  logic        last_pop;

  logic          fifo_empty;
  logic          fifo_full_unused;
  logic [CW-1:0] fifo_count;
  logic          rlast_unused;

  // Beats are counted per handshake, so RLAST carries no extra information.
  assign rlast_unused = M_RLAST;

  // Burst size: the smallest of the burst cap, the rest of the row and the
  // distance to the next 4 KB page, so no burst ever crosses a page.
  always_comb begin
    beats_4k    = (32'(AXI_4KB) - {20'd0, cur_addr_q[11:0]}) >> SZ;
    burst_beats = 32'(MAX_BURST);
    if ({16'd0, beats_left_q} < burst_beats) begin
      burst_beats = {16'd0, beats_left_q};
    end
    if (beats_4k < burst_beats) begin
      burst_beats = beats_4k;
    end
  end

  // Everything already requested plus everything queued must fit in the FIFO.
  // reserved + count only shrinks between AR handshakes, so once ARVALID is
  // raised it stays high with a stable address and length until accepted.
  assign credit_ok = (reserved_q + burst_beats) <= (32'(FIFO_DEPTH) - 32'(fifo_count));
  assign ar_vld    = (state_q == ST_ISSUE) && credit_ok;
  assign ar_hs     = ar_vld && M_ARREADY;
  assign r_hs      = M_RVALID && busy_q;
  assign pop       = !fifo_empty && i_ready;

  assign head_is_last = busy_q && (popped_q == total_q - 32'd1);
  assign last_pop     = pop && head_is_last && (rcvd_q == total_q);

  assign start_row_beats  = i_row_bytes >> SZ;
  assign beats_left_after = beats_left_q - burst_beats[15:0];

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    row_start_d  = row_start_q;
    cur_addr_d   = cur_addr_q;
    stride_d     = stride_q;
    row_beats_d  = row_beats_q;
    beats_left_d = beats_left_q;
    rows_left_d  = rows_left_q;
    total_d      = total_q;
    rcvd_d       = rcvd_q;
    popped_d     = popped_q;

    // An AR handshake and an R beat in the same cycle net out here.
    reserved_d = reserved_q + (ar_hs ? burst_beats : 32'd0) - (r_hs ? 32'd1 : 32'd0);

    if (r_hs) begin
      rcvd_d = rcvd_q + 32'd1;
      if (M_RRESP != AXI_RESP_OKAY) begin
        err_d = 1'b1;
      end
    end
    if (pop) begin
      popped_d = popped_q + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          err_d = 1'b0;
          if ((i_num_rows == 16'd0) || (start_row_beats == 16'd0)) begin
            // Empty region: report completion without touching the bus.
            done_d = 1'b1;
          end else begin
            state_d      = ST_ISSUE;
            busy_d       = 1'b1;
            row_start_d  = i_base_addr;
            cur_addr_d   = i_base_addr;
            stride_d     = i_row_stride;
            row_beats_d  = start_row_beats;
            beats_left_d = start_row_beats;
            rows_left_d  = i_num_rows;
            total_d      = 32'(i_num_rows) * 32'(start_row_beats);
            reserved_d   = 32'd0;
            rcvd_d       = 32'd0;
            popped_d     = 32'd0;
          end
        end
      end
      ST_ISSUE: begin
        if (ar_hs) begin
          if (beats_left_after == 16'd0) begin
            if (rows_left_q == 16'd1) begin
              state_d = ST_DRAIN;
            end else begin
              // Row start advances by the stride; wrap-around is intended.
              rows_left_d  = rows_left_q - 16'd1;
              row_start_d  = row_start_q + stride_q;
              cur_addr_d   = row_start_q + stride_q;
              beats_left_d = row_beats_q;
            end
          end else begin
            cur_addr_d   = cur_addr_q + A'(burst_beats << SZ);
            beats_left_d = beats_left_after;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DRAIN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Final beat leaving the stream ends the transfer.
    if (last_pop) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      row_start_q  <= '0;
      cur_addr_q   <= '0;
      stride_q     <= '0;
      row_beats_q  <= '0;
      beats_left_q <= '0;
      rows_left_q  <= '0;
      total_q      <= '0;
      reserved_q   <= '0;
      rcvd_q       <= '0;
      popped_q     <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      row_start_q  <= row_start_d;
      cur_addr_q   <= cur_addr_d;
      stride_q     <= stride_d;
      row_beats_q  <= row_beats_d;
      beats_left_q <= beats_left_d;
      rows_left_q  <= rows_left_d;
      total_q      <= total_d;
      reserved_q   <= reserved_d;
      rcvd_q       <= rcvd_d;
      popped_q     <= popped_d;
    end
  end

  rd_data_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (D)
  ) u_rd_data_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .i_push     (r_hs),
    .i_push_dat (M_RDATA),
    .i_pop      (pop),
    .o_head_dat (o_data),
    .o_empty    (fifo_empty),
    .o_full     (fifo_full_unused),
    .o_count    (fifo_count)
  );

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err     = err_q;
  assign M_ARVALID = ar_vld;
  assign M_ARADDR  = cur_addr_q;
  assign M_ARID    = I'(AR_ID);
  assign M_ARLEN   = ar_vld ? L'(burst_beats - 32'd1) : '0;
  assign M_ARSIZE  = ar_vld ? 3'(SZ) : 3'd0;
  assign M_ARBURST = ar_vld ? AXI_BURST_INCR : 2'b00;
  assign M_RREADY  = busy_q;
  assign o_valid   = !fifo_empty;
  assign o_last    = !fifo_empty && head_is_last;

endmodule
